// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory program loader; optional checksum via IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK  = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

    localparam logic [16:0] CAP = 17'd1 << ADDR_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         rem_q, rem_d;
    logic                imem_we_q, imem_we_d;
    logic [31:0]         imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                core_hold_q, core_hold_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   xor_q, xor_d;
`endif

    logic        beat;
    logic [15:0] hdr_base, hdr_len;
    logic [16:0] hdr_end;
    logic        hdr_range_ok;
    logic        last_word;

    assign beat         = in_valid && in_ready;
    assign hdr_base     = in_data[31:16];
    assign hdr_len      = in_data[15:0];
    assign hdr_end      = {1'b0, hdr_base} + {1'b0, hdr_len};
    assign hdr_range_ok = (hdr_end <= CAP);
    assign last_word    = (rem_q == 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_hold_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_hold_q  <= core_hold_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (beat && hdr_len != 16'd0 && hdr_range_ok) begin
                    state_d = S_LOAD;
                end else if (beat && hdr_len == 16'd0) begin
                    state_d = S_DONE;
                end
            end
            S_LOAD: begin
                if (beat && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (beat) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_IDLE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        rem_d        = rem_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_hold_d  = core_hold_q;
        load_done_d  = 1'b0;
        load_err_d   = load_err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        in_ready     = !rst && (state_q != S_DONE);
        case (state_q)
            S_IDLE: begin
                // Any accepted header clears the previous error before its own range check.
                if (beat) begin
                    load_err_d = 1'b0;
                    if (hdr_len != 16'd0) begin
                        if (!hdr_range_ok) begin
                            load_err_d = 1'b1;
                        end else begin
                            addr_d      = hdr_base[ADDR_W-1:0];
                            rem_d       = hdr_len;
                            core_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            xor_d       = '0;
`endif
                        end
                    end
                end
            end
            S_LOAD: begin
                if (beat) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = 32'(addr_q) << 2;
                    imem_wdata_d = in_data;
                    addr_d       = addr_q + ADDR_W'(1);
                    rem_d        = rem_q - 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d        = xor_q ^ in_data;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (beat && in_data != xor_q) begin
                    load_err_d = 1'b1;
                end
            end
`endif
            S_DONE: begin
                load_done_d = 1'b1;
                core_hold_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_hold  = core_hold_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a behavioural load model
module tb_imem_loader;

    localparam int CAP = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    imem_loader #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t  wr_q[$];
    int   done_q[$];
    int   fall_q[$];
    logic hold_prev;

    always @(negedge clk) begin
        wr_t w;
        if (imem_we === 1'b1) begin
            w.c = cyc; w.a = imem_addr; w.d = imem_wdata;
            wr_q.push_back(w);
        end
        if (load_done === 1'b1) done_q.push_back(cyc);
        if (hold_prev === 1'b1 && core_hold === 1'b0) fall_q.push_back(cyc);
        hold_prev = core_hold;
    end

    task automatic send(input logic [31:0] w, output int acc);
        int n;
        n = 0;
        acc = -1;
        in_valid = 1'b1;
        in_data  = w;
        while (acc < 0 && n < 20) begin
            @(negedge clk);
            if (in_ready === 1'b1) acc = cyc;
            else begin
                n++;
                @(posedge clk); #1;
            end
        end
        if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Model: a load of len words from base writes word i to byte address (base+i)*4,
    // one cycle after its beat; done and hold release come 2 cycles after the last beat.
    task automatic do_load(input int base, input int len, input int gap, input bit bad_csum, input bit seq);
        int          h, last, g, nchk;
        int          acc[$];
        logic [31:0] words[$];
        logic [31:0] w, csum, hdr;
        logic        hold_before;
        bit          ok, fail_csum;
        wr_q.delete(); done_q.delete(); fall_q.delete();
        hold_before = core_hold;
        ok = (len == 0) || (base + len <= CAP);
        hdr = (32'(base) << 16) | 32'(len & 16'hFFFF);
        send(hdr, h);
        if (!ok) begin
            check("err_set", {31'd0, load_err}, 32'd1);
            check("err_hold", {31'd0, core_hold}, {31'd0, hold_before});
            check("err_ready", {31'd0, in_ready}, 32'd1);
            repeat (2) @(posedge clk); #1;
            check("err_nowrite", wr_q.size(), 32'd0);
            check("err_nodone", done_q.size(), 32'd0);
            check("err_hold2", {31'd0, core_hold}, {31'd0, hold_before});
            return;
        end
        check("hdr_err_clr", {31'd0, load_err}, 32'd0);
        if (len > 0) check("hdr_hold", {31'd0, core_hold}, 32'd1);
        last = h;
        csum = 32'd0;
        for (int i = 0; i < len; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                @(negedge clk);
                check("gap_hold", {31'd0, core_hold}, 32'd1);
                @(posedge clk); #1;
            end
            w = seq ? 32'(i + 1) : $urandom;
            words.push_back(w);
            csum ^= w;
            send(w, last);
            acc.push_back(last);
        end
        fail_csum = 1'b0;
        if (CSUM_EN && len > 0) begin
            fail_csum = bad_csum;
            send(bad_csum ? (csum ^ 32'h7) : csum, last);
        end
        repeat (2) @(posedge clk); #1;
        check("wr_count", wr_q.size(), 32'(len));
        nchk = (wr_q.size() < len) ? wr_q.size() : len;
        for (int i = 0; i < nchk; i++) begin
            check("wr_addr", wr_q[i].a, 32'((base + i) * 4));
            check("wr_data", wr_q[i].d, words[i]);
            check("wr_cycle", wr_q[i].c, 32'(acc[i] + 1));
        end
        if (fail_csum) begin
            check("csum_err", {31'd0, load_err}, 32'd1);
            check("csum_hold", {31'd0, core_hold}, 32'd1);
            check("csum_nodone", done_q.size(), 32'd0);
        end else begin
            check("done_count", done_q.size(), 32'd1);
            if (done_q.size() > 0) check("done_cycle", done_q[0], 32'(last + 2));
            check("done_hold", {31'd0, core_hold}, 32'd0);
            check("done_err", {31'd0, load_err}, 32'd0);
            if (len > 0 || hold_before) begin
                check("fall_count", fall_q.size(), 32'd1);
                if (fall_q.size() > 0) check("fall_cycle", fall_q[0], 32'(last + 2));
            end else begin
                check("fall_none", fall_q.size(), 32'd0);
            end
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({pfx, "_we"}, {31'd0, imem_we}, 32'd0);
        check({pfx, "_addr"}, imem_addr, 32'd0);
        check({pfx, "_wdata"}, imem_wdata, 32'd0);
        check({pfx, "_done"}, {31'd0, load_done}, 32'd0);
        check({pfx, "_err"}, {31'd0, load_err}, 32'd0);
        check({pfx, "_hold"}, {31'd0, core_hold}, 32'd1);
    endtask

    initial begin
        int acc, base, len;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 32'd0;
        repeat (2) @(posedge clk); #1;
        check_reset_values("reset");
        rst = 1'b0;
        #1;
        check("reset_ready_after", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        do_load(0, 3, 0, 1'b0, 1'b0);
        do_load(16, 2, 3, 1'b0, 1'b0);
        do_load(16'h03FF, 2, 0, 1'b0, 1'b0);
        do_load(0, 0, 0, 1'b0, 1'b0);
        if (CSUM_EN) begin
            do_load(48, 2, 0, 1'b0, 1'b1);
            do_load(48, 2, 0, 1'b1, 1'b1);
        end
        do_load(16'h0400, 1, 0, 1'b0, 1'b0);

        // Reset after the first of four data words.
        wr_q.delete();
        send(32'h0020_0004, acc);
        send(32'hDEAD_BEEF, acc);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midrst");
        check("midrst_wr_count", wr_q.size(), 32'd1);
        if (wr_q.size() > 0) check("midrst_wr_addr", wr_q[0].a, 32'h80);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        do_load(32, 4, 0, 1'b0, 1'b0);
        do_load(CAP - 3, 3, -1, 1'b0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            base = $urandom_range(0, CAP - 1);
            if ($urandom_range(0, 3) == 0) len = $urandom_range(CAP - base + 1, 65535);
            else len = $urandom_range(0, ((CAP - base) < 6) ? (CAP - base) : 6);
            do_load(base, len, -1, CSUM_EN && ($urandom_range(0, 2) == 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader on the write side of the instruction memory that the fetch stage reads. It accepts a word stream from the node's network interface, with a header word followed by instruction words, and writes each word into instruction memory at consecutive word addresses. It holds the core's PC/fetch pipeline until a complete program has been written. It sits between the NoC receive port and the instruction memory write port, one per processing element.

## Interface
- `ADDR_W`, 10: instruction memory word-address width; capacity is 2^ADDR_W words.
- `DATA_W`, 32: instruction word width. Fixed at 32; other values are unsupported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  loader can accept a word. A beat transfers when `in_valid && in_ready`.
- `in_data`  in  32  stream word.
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  32  byte address, equal to word index << 2; the same addressing as the fetch PC.
- `imem_wdata`  out  32  word to write.
- `core_hold`  out  1  freeze PC and fetch while high.
- `load_done`  out  1  one-cycle pulse when a program load completes successfully.
- `load_err`  out  1  sticky error flag; cleared by `rst` or by the next accepted header.

## Operation
- Header word format: `base` = `in_data[31:16]`, the start word index; `len` = `in_data[15:0]`, the word count.
- States:
  - IDLE: `in_ready`=1. On a header beat:
    - If `len`==0: go to DONE.
    - If `base + len > 2^ADDR_W`, computed at 17 bits: set `load_err`, stay in IDLE. `core_hold` is unchanged.
    - Otherwise: latch `base` into the address counter and `len` into the remaining counter, assert `core_hold`, go to LOAD.
  - LOAD: `in_ready`=1. On each beat, write the word at the current counter, then increment the counter and decrement the remaining count. On the beat that brings the remaining count to 0, go to CHK if `IMEM_LOADER_CHECKSUM_EN` is defined, otherwise to DONE.
  - CHK: `in_ready`=1. The next beat is the checksum and is not written to memory.
    - Match: go to DONE.
    - Mismatch: set `load_err`, go to IDLE with `core_hold` kept high.
  - DONE: `in_ready`=0 for this one cycle. Pulse `load_done`, clear `core_hold`, go to IDLE.
- A header accepted in IDLE while the core is running re-asserts `core_hold` (reload). A rejected header leaves `core_hold` as it was.
- Address arithmetic is modulo 2^ADDR_W. The range check guarantees wrap never occurs within a load.
- `in_valid` low during LOAD: the loader simply waits. There is no timeout.

## Timing
- Reset values: `core_hold`=1, so the core is held until the first successful load. `in_ready`=0 during the reset cycle and 1 from the next cycle. `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `load_done`=0, `load_err`=0. State is IDLE.
- Writes are registered. A beat accepted in cycle N produces `imem_we`=1 with its address and data in cycle N+1. Peak throughput is one word per cycle.
- `load_done` is high, and `core_hold` falls, in the cycle after the state enters DONE. That is 2 cycles after the last data beat (or checksum beat) is accepted; the final `imem_we` has completed by then.
- `rst` asserted mid-load: return to IDLE next cycle with all reset values and `core_hold`=1. Partially written memory contents are left as-is.
- `load_err` and a fresh header in the same cycle: the header clears the error, and the new range check then applies.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: CHK state is present. The expected checksum is the 32-bit XOR of all data words of the load, with the running XOR cleared on header accept. A `len`==0 load skips CHK.
- Not defined: no CHK state and no XOR register; LOAD goes directly to DONE.

## Test plan
- Reset, then header 0x0000_0003 and words A, B, C back-to-back -> writes to addresses 0x0, 0x4, 0x8 on consecutive cycles; `load_done` pulses once; `core_hold` falls 2 cycles after C is accepted.
- Header 0x0010_0002 with `in_valid` gapped by 3 idle cycles between words -> writes to 0x40 and 0x44 only; `core_hold` stays high throughout the gap.
- Header 0x03FF_0002 with `ADDR_W`=10 -> `load_err`=1, no `imem_we`, state stays IDLE, `core_hold` unchanged.
- Header 0x0000_0000 -> `load_done` pulses 2 cycles later with no writes.
- With `IMEM_LOADER_CHECKSUM_EN`: words 0x1, 0x2 followed by checksum 0x3 -> `load_done`. Repeating with checksum 0x4 -> `load_err`=1 and `core_hold` stays 1.
- `rst` asserted after 1 of 4 data words -> all outputs return to reset values next cycle; a following valid load completes normally.
